// File: rtl/srio_pkg.sv
// ----------------------------------------------------------------------------
// srio_pkg
// Shared definitions for the SRIO initiator-request path: arbiter state
// encoding, SRIO ftype codes and the default legal packet length in beats.
// No ports (package).
// ----------------------------------------------------------------------------
package srio_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

   // Header beat plus 32 data beats.
   localparam int SRIO_MAX_BEATS = 33;

   localparam logic [3:0] FTYPE_NREAD    = 4'd2;
   localparam logic [3:0] FTYPE_NWRITE   = 4'd5;
   localparam logic [3:0] FTYPE_DOORBELL = 4'd10;
   localparam logic [3:0] FTYPE_MESSAGE  = 4'd11;

endpackage

// File: rtl/srio_ireq_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: returns the first asserted request at
// or after ptr_i, wrapping past N_SRC-1 back to 0.
// Ports:
//   req_i  [N_SRC-1:0]  request vector
//   ptr_i  [PW-1:0]     highest-priority index
//   gnt_o  [N_SRC-1:0]  one-hot selection, zero when no request
// ----------------------------------------------------------------------------
module rr_pick #(
   parameter  int N_SRC = 4,
   localparam int PW    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic [N_SRC-1:0] req_i,
   input  logic [PW-1:0]    ptr_i,
   output logic [N_SRC-1:0] gnt_o
);

   logic found;

   // First pass covers indices ptr..N-1, second pass the wrapped 0..ptr-1.
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      for (int k = 0; k < N_SRC; k++) begin
         if (!found && req_i[k] && (k >= int'(ptr_i))) begin
            gnt_o[k] = 1'b1;
            found    = 1'b1;
         end
      end
      for (int k = 0; k < N_SRC; k++) begin
         if (!found && req_i[k]) begin
            gnt_o[k] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/srio_ireq_arbiter.sv
// ----------------------------------------------------------------------------
// srio_ireq_arbiter
// Packet-level round-robin arbiter merging N_SRC AXI-Stream requesters onto
// the SRIO core initiator request channel. The grant is held for a whole
// packet; one idle cycle separates packets for arbitration.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no owner, all treadys low, picking next requester
//   ST_BUSY | owner in o_grant, its stream forwarded until tlast accepted
//
// Ports:
//   i_clk, i_rst                 clock, async active-high reset
//   s_axis_req_*  [N_SRC lanes]  requester streams (packed, lane k at k*W)
//   m_axis_ireq_*                merged stream toward the SRIO core
//   o_grant                      one-hot current owner, zero when idle
//   o_busy                       packet in flight
//   o_len_err                    one-cycle pulse when MAX_BEATS reached w/o tlast
// ----------------------------------------------------------------------------
module srio_ireq_arbiter
   import srio_pkg::*;
#(
   parameter int N_SRC     = 4,
   parameter int MAX_BEATS = SRIO_MAX_BEATS
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [N_SRC-1:0]      s_axis_req_tvalid,
   output logic [N_SRC-1:0]      s_axis_req_tready,
   input  logic [N_SRC-1:0]      s_axis_req_tlast,
   input  logic [64*N_SRC-1:0]   s_axis_req_tdata,
   input  logic [8*N_SRC-1:0]    s_axis_req_tkeep,
   input  logic [32*N_SRC-1:0]   s_axis_req_tuser,
   output logic                  m_axis_ireq_tvalid,
   input  logic                  m_axis_ireq_tready,
   output logic                  m_axis_ireq_tlast,
   output logic [63:0]           m_axis_ireq_tdata,
   output logic [7:0]            m_axis_ireq_tkeep,
   output logic [31:0]           m_axis_ireq_tuser,
   output logic [N_SRC-1:0]      o_grant,
   output logic                  o_busy,
   output logic                  o_len_err
);

   localparam int          PW        = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam logic [15:0] LEN_LIMIT = 16'(MAX_BEATS);

   arb_state_e       state_q;
   logic [N_SRC-1:0] grant_q;
   logic [PW-1:0]    gidx_q;
   logic [PW-1:0]    rr_ptr_q;
   logic [15:0]      beat_cnt_q;
   logic             len_err_q;

   logic [N_SRC-1:0] pick;
   logic [PW-1:0]    pick_idx;
   logic             busy;
   logic             hs;
   logic             sel_valid;
   logic             sel_last;
   logic [63:0]      sel_data;
   logic [7:0]       sel_keep;
   logic [31:0]      sel_user;

   rr_pick #(.N_SRC(N_SRC)) u_rr_pick (
      .req_i (s_axis_req_tvalid),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick)
   );

   always_comb begin
      pick_idx = '0;
      for (int k = 0; k < N_SRC; k++) begin
         if (pick[k]) pick_idx = PW'(k);
      end
   end

   // grant_q is zero while idle, so the mux outputs zero fields then.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      sel_keep  = '0;
      sel_user  = '0;
      for (int k = 0; k < N_SRC; k++) begin
         if (grant_q[k]) begin
            sel_valid = s_axis_req_tvalid[k];
            sel_last  = s_axis_req_tlast[k];
            sel_data  = s_axis_req_tdata[64*k +: 64];
            sel_keep  = s_axis_req_tkeep[8*k +: 8];
            sel_user  = s_axis_req_tuser[32*k +: 32];
         end
      end
   end

   assign busy               = (state_q == ST_BUSY);
   assign m_axis_ireq_tvalid = busy & sel_valid;
   assign m_axis_ireq_tlast  = sel_last;
   assign m_axis_ireq_tdata  = sel_data;
   assign m_axis_ireq_tkeep  = sel_keep;
   assign m_axis_ireq_tuser  = sel_user;
   assign s_axis_req_tready  = busy ? (grant_q & {N_SRC{m_axis_ireq_tready}}) : '0;
   assign hs                 = m_axis_ireq_tvalid & m_axis_ireq_tready;

   assign o_grant   = grant_q;
   assign o_busy    = busy;
   assign o_len_err = len_err_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         gidx_q     <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         len_err_q  <= 1'b0;
      end else begin
         len_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (|s_axis_req_tvalid) begin
                  state_q    <= ST_BUSY;
                  grant_q    <= pick;
                  gidx_q     <= pick_idx;
                  beat_cnt_q <= '0;
               end
            end
            ST_BUSY: begin
               if (hs) begin
                  if (m_axis_ireq_tlast) begin
                     state_q    <= ST_IDLE;
                     grant_q    <= '0;
                     beat_cnt_q <= '0;
                     rr_ptr_q   <= (gidx_q == PW'(N_SRC - 1)) ? '0 : gidx_q + PW'(1);
                  end else begin
                     // Saturate so an endless packet cannot wrap and re-flag.
                     if (beat_cnt_q != 16'hFFFF) beat_cnt_q <= beat_cnt_q + 16'd1;
                     if (beat_cnt_q == LEN_LIMIT - 16'd1) len_err_q <= 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_srio_ireq_arbiter.sv
// ----------------------------------------------------------------------------
// tb_srio_ireq_arbiter
// Randomised requester streams with a packet-level reference model and an
// output scoreboard; directed phases cover contention, single-beat packets,
// back-pressure, over-length packets and reset mid-packet.
// ----------------------------------------------------------------------------
module tb_srio_ireq_arbiter;

   localparam int N    = 4;
   localparam int MAXB = 33;

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic [31:0] u;
      logic        l;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     s_tvalid, s_tready, s_tlast;
   logic [64*N-1:0]  s_tdata;
   logic [8*N-1:0]   s_tkeep;
   logic [32*N-1:0]  s_tuser;
   logic             m_tvalid, m_tready, m_tlast;
   logic [63:0]      m_tdata;
   logic [7:0]       m_tkeep;
   logic [31:0]      m_tuser;
   logic [N-1:0]     o_grant;
   logic             o_busy, o_len_err;

   always #5 clk = ~clk;

   srio_ireq_arbiter #(.N_SRC(N), .MAX_BEATS(MAXB)) dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .s_axis_req_tvalid  (s_tvalid),
      .s_axis_req_tready  (s_tready),
      .s_axis_req_tlast   (s_tlast),
      .s_axis_req_tdata   (s_tdata),
      .s_axis_req_tkeep   (s_tkeep),
      .s_axis_req_tuser   (s_tuser),
      .m_axis_ireq_tvalid (m_tvalid),
      .m_axis_ireq_tready (m_tready),
      .m_axis_ireq_tlast  (m_tlast),
      .m_axis_ireq_tdata  (m_tdata),
      .m_axis_ireq_tkeep  (m_tkeep),
      .m_axis_ireq_tuser  (m_tuser),
      .o_grant            (o_grant),
      .o_busy             (o_busy),
      .o_len_err          (o_len_err)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- requester drivers ----------------
   int pkt_q[N][$];
   int cur_len[N];
   int beat[N];
   bit hs_prev[N];
   int pv = 100;
   int pr = 100;

   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < N; k++) hs_prev[k] = s_tvalid[k] & s_tready[k];
      end
   end

   task automatic step();
      bit hold;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         hold = s_tvalid[k] && !hs_prev[k];
         if (hs_prev[k] && cur_len[k] != 0) begin
            beat[k]++;
            if (beat[k] == cur_len[k]) cur_len[k] = 0;
         end
         if (cur_len[k] == 0 && pkt_q[k].size() > 0) begin
            cur_len[k] = pkt_q[k].pop_front();
            beat[k]    = 0;
            hold       = 1'b0;
         end
         if (cur_len[k] == 0) begin
            s_tvalid[k] = 1'b0;
         end else if (!hold) begin
            s_tvalid[k]          = ($urandom_range(99) < pv);
            s_tdata[64*k +: 64]  = {$urandom, $urandom};
            s_tkeep[8*k +: 8]    = 8'($urandom);
            s_tuser[32*k +: 32]  = $urandom;
            s_tlast[k]           = (beat[k] == cur_len[k] - 1);
         end
      end
      m_tready = ($urandom_range(99) < pr);
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      for (int k = 0; k < N; k++) begin
         pkt_q[k].delete();
         cur_len[k] = 0;
         beat[k]    = 0;
      end
      s_tvalid = '0;
      s_tlast  = '0;
      repeat (cycles) step();
      rst = 1'b0;
   endtask

   // ---------------- reference model ----------------
   bit           m_busy;
   int           m_owner, m_ptr, m_cnt;
   bit           m_lerr_pend;
   logic [N-1:0] exp_grant, exp_tready;
   logic         exp_busy, exp_lerr, exp_mvalid;
   beat_t        exp_q[$];

   initial begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_lerr_pend = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_busy = 0; m_ptr = 0; m_cnt = 0; m_lerr_pend = 0;
            exp_grant = '0; exp_busy = 0; exp_lerr = 0; exp_mvalid = 0; exp_tready = '0;
            exp_q.delete();
         end else begin
            exp_grant = m_busy ? (N'(1) << m_owner) : '0;
            exp_busy  = m_busy;
            exp_lerr  = m_lerr_pend;
            m_lerr_pend = 0;
            if (m_busy) begin
               exp_mvalid = s_tvalid[m_owner];
               exp_tready = m_tready ? (N'(1) << m_owner) : '0;
               if (s_tvalid[m_owner] && m_tready) begin
                  exp_q.push_back('{d: s_tdata[64*m_owner +: 64], k: s_tkeep[8*m_owner +: 8],
                                    u: s_tuser[32*m_owner +: 32], l: s_tlast[m_owner]});
                  m_cnt++;
                  if (s_tlast[m_owner]) begin
                     m_busy = 0;
                     m_ptr  = (m_owner + 1) % N;
                     m_cnt  = 0;
                  end else if (m_cnt == MAXB) begin
                     m_lerr_pend = 1;
                  end
               end
            end else begin
               bit found;
               exp_mvalid = 1'b0;
               exp_tready = '0;
               found = 0;
               for (int i = 0; i < N; i++) begin
                  if (!found && s_tvalid[(m_ptr + i) % N]) begin
                     m_owner = (m_ptr + i) % N;
                     found   = 1;
                  end
               end
               if (found) begin
                  m_busy = 1;
                  m_cnt  = 0;
               end
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   int           n_out = 0;
   int           n_lerr = 0;
   int           lerr_at = -1;
   int           pkt_beats = 0;
   int           order_log[$];
   int           exp_order[$];
   logic [N-1:0] prev_grant = '0;
   bit           prev_stall = 0;
   logic [63:0]  prev_data;
   logic         prev_last;

   initial begin
      beat_t b;
      forever begin
         @(negedge clk);
         #1;
         chk("grant", 64'(o_grant), 64'(exp_grant));
         chk("busy", 64'(o_busy), 64'(exp_busy));
         chk("len_err", 64'(o_len_err), 64'(exp_lerr));
         chk("m_tvalid", 64'(m_tvalid), 64'(exp_mvalid));
         chk("s_tready", 64'(s_tready), 64'(exp_tready));
         if (o_grant != '0 && prev_grant == '0) begin
            pkt_beats = 0;
            for (int k = 0; k < N; k++) if (o_grant[k]) order_log.push_back(k);
         end
         prev_grant = o_grant;
         if (o_len_err) begin
            n_lerr++;
            lerr_at = pkt_beats;
         end
         if (!rst && prev_stall) begin
            chk("stall_data", m_tdata, prev_data);
            chk("stall_last", 64'(m_tlast), 64'(prev_last));
         end
         prev_stall = !rst && m_tvalid && !m_tready;
         prev_data  = m_tdata;
         prev_last  = m_tlast;
         if (m_tvalid && m_tready) begin
            n_out++;
            pkt_beats++;
            if (exp_q.size() == 0) begin
               chk("beat_expected", 64'(0), 64'(1));
            end else begin
               b = exp_q.pop_front();
               chk("m_tdata", m_tdata, b.d);
               chk("m_tkeep", 64'(m_tkeep), 64'(b.k));
               chk("m_tuser", 64'(m_tuser), 64'(b.u));
               chk("m_tlast", 64'(m_tlast), 64'(b.l));
            end
         end
      end
   end

   task automatic check_order(input string nm);
      chk({nm, "_count"}, 64'(order_log.size()), 64'(exp_order.size()));
      for (int i = 0; i < exp_order.size() && i < order_log.size(); i++)
         chk(nm, 64'(order_log[i]), 64'(exp_order[i]));
      order_log.delete();
      exp_order.delete();
   endtask

   function automatic bit all_idle();
      bit r = !m_busy;
      for (int k = 0; k < N; k++) if (pkt_q[k].size() != 0 || cur_len[k] != 0) r = 0;
      return r;
   endfunction

   task automatic drain(input int limit);
      int c = 0;
      while (!all_idle() && c < limit) begin
         step();
         c++;
      end
      chk("drain_done", 64'(c < limit), 64'(1));
      repeat (3) step();
   endtask

   // ---------------- phases ----------------
   int base_out;
   int c;

   initial begin
      rst = 1'b1;
      s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0; s_tuser = '0;
      m_tready = 1'b0;
      for (int k = 0; k < N; k++) begin cur_len[k] = 0; beat[k] = 0; end
      repeat (3) step();
      chk("reset_grant", 64'(o_grant), 64'(0));
      chk("reset_tready", 64'(s_tready), 64'(0));
      rst = 1'b0;

      // Requesters 0 and 2 contend with full-length packets.
      pv = 100; pr = 100;
      order_log.delete();
      pkt_q[0].push_back(33);
      pkt_q[2].push_back(33);
      drain(500);
      exp_order = '{0, 2};
      check_order("order_contend");

      // All four requesters streaming single-beat packets.
      do_reset(2);
      order_log.delete();
      for (int k = 0; k < N; k++) begin pkt_q[k].push_back(1); pkt_q[k].push_back(1); end
      drain(500);
      exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
      check_order("order_single");

      // Back-pressure on a full-length packet.
      pr = 50;
      base_out = n_out;
      pkt_q[1].push_back(33);
      drain(1000);
      chk("bp_beats", 64'(n_out - base_out), 64'(33));

      // Over-length packet.
      pr = 100;
      base_out = n_out;
      n_lerr = 0;
      pkt_q[3].push_back(40);
      drain(500);
      chk("ovl_beats", 64'(n_out - base_out), 64'(40));
      chk("ovl_pulses", 64'(n_lerr), 64'(1));
      chk("ovl_at_beat", 64'(lerr_at), 64'(33));

      // Reset in the middle of a packet from requester 2.
      order_log.delete();
      pkt_q[1].push_back(1);
      pkt_q[2].push_back(33);
      c = 0;
      while ((cur_len[2] == 0 || beat[2] < 10) && c < 500) begin step(); c++; end
      chk("mid_reached", 64'(c < 500), 64'(1));
      exp_order = '{1, 2};
      check_order("order_pre_rst");
      do_reset(1);
      chk("rst_grant", 64'(o_grant), 64'(0));
      chk("rst_mvalid", 64'(m_tvalid), 64'(0));
      pkt_q[0].push_back(2);
      pkt_q[2].push_back(2);
      drain(500);
      exp_order = '{0, 2};
      check_order("order_post_rst");

      // Random traffic.
      pv = 75; pr = 60;
      for (int k = 0; k < N; k++)
         for (int p = 0; p < 10; p++) pkt_q[k].push_back(int'($urandom_range(1, 40)));
      drain(20000);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/srio_ireq_arbiter.md
SRIO_IREQ_ARBITER -- requirements
Module: srio_ireq_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4, meaning number of requester ports (2..8).
REQ-002 SHALL have parameter MAX_BEATS, default 33, meaning legal beats per packet (header + 32 data).
REQ-003 SHALL have port i_clk, input, 1, meaning sole clock.
REQ-004 SHALL have port i_rst, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port s_axis_req_tvalid, input, N_SRC, meaning per-requester valid.
REQ-006 SHALL have port s_axis_req_tready, output, N_SRC, meaning per-requester ready.
REQ-007 SHALL have port s_axis_req_tlast, input, N_SRC, meaning per-requester last beat.
REQ-008 SHALL have port s_axis_req_tdata, input, 64*N_SRC, meaning packed data, requester k at [64k+63:64k].
REQ-009 SHALL have port s_axis_req_tkeep, input, 8*N_SRC, meaning packed keep.
REQ-010 SHALL have port s_axis_req_tuser, input, 32*N_SRC, meaning packed user.
REQ-011 SHALL have ports m_axis_ireq_tvalid/tready/tlast/tdata/tkeep/tuser, out/in/out/out/out/out, 1/1/1/64/8/32, meaning SRIO core initiator request channel.
REQ-012 SHALL have port o_grant, output, N_SRC, meaning one-hot current owner, zero when idle.
REQ-013 SHALL have port o_busy, output, 1, meaning a packet is in flight.
REQ-014 SHALL have port o_len_err, output, 1, meaning one-cycle pulse on over-length packet.

Function
REQ-015 SHALL implement states ST_IDLE and ST_BUSY.
REQ-016 In ST_IDLE with any s_axis_req_tvalid high, SHALL select the first valid requester at or after r_rr_ptr (wrapping modulo N_SRC) and enter ST_BUSY next cycle with o_grant registered to it.
REQ-017 In ST_IDLE SHALL drive all s_axis_req_tready low and m_axis_ireq_tvalid low.
REQ-018 In ST_BUSY SHALL forward granted requester's tvalid/tlast/tdata/tkeep/tuser to m_axis_ireq combinationally and route m_axis_ireq_tready to that requester's tready only; all other treadys 0.
REQ-019 SHALL hold the grant for the whole packet; other requesters' tvalid changes SHALL NOT affect the grant.
REQ-020 On m_axis_ireq_tvalid & tready & tlast in ST_BUSY, SHALL return to ST_IDLE and set r_rr_ptr to (granted index + 1) mod N_SRC.
REQ-021 Packet-to-packet gap SHALL be exactly one idle cycle (arbitration bubble); valid-to-first-output latency SHALL be one cycle.
REQ-022 SHALL count accepted beats in a 16-bit counter cleared on packet end; when the count reaches MAX_BEATS without tlast, SHALL pulse o_len_err once and keep forwarding (no truncation).
REQ-023 Single-beat packets (tlast on first beat, e.g. NREAD, DOORBELL) SHALL be forwarded and release the grant identically.
REQ-024 Granted requester deasserting tvalid mid-packet SHALL stall output (m tvalid low) without losing grant.
REQ-025 m_axis_ireq_tready low SHALL stall with all output fields stable.
REQ-026 o_busy SHALL equal (state == ST_BUSY).

Reset
REQ-027 On i_rst high, state SHALL be ST_IDLE, r_rr_ptr 0, o_grant 0, beat counter 0, o_len_err 0, all tready 0, m_axis_ireq_tvalid 0.
REQ-028 Reset mid-packet SHALL abandon the packet immediately; no resumption after release.

Structure
REQ-029 State encodings, SRIO ftype constants (NWRITE 5, NREAD 2, DOORBELL 10, MESSAGE 11) and default MAX_BEATS SHALL live in a shared srio_pkg package.
REQ-030 Round-robin selection SHALL be one sub-module rr_pick (request vector + pointer in, one-hot out, combinational).

Verification
REQ-031 Requesters 0 and 2 valid together from reset -> 0 granted first (33 beats), one idle cycle, then 2 granted.
REQ-032 All 4 requesters continuously valid, single-beat packets -> grant order 0,1,2,3,0 with one bubble each.
REQ-033 m tready toggled 50% during 33-beat packet from requester 1 -> all 33 beats delivered in order, data stable while stalled.
REQ-034 Requester 3 sends 40 beats without tlast until beat 40 -> o_len_err pulses once at beat 33, all 40 beats forwarded.
REQ-035 i_rst asserted at beat 10 of a packet -> next cycle o_grant 0, m tvalid 0; after release requester 0 re-arbitrated from pointer 0.
